// File: rtl/ret_stack.sv
// ret_stack: hardware return-address stack that sits beside the program counter.
// It decodes CALL / RET / JMP requests, pushes pc+1 on CALL, pops on RET, and
// drives a combinational load strobe and load value so the PC and the stack
// update on the same clock edge.
//
// Optional feature: define RET_STACK_OVF_TRAP_EN to turn overflow and underflow
// into traps (jump to TRAP_VEC and set fault). When the macro is not defined,
// overflow overwrites the oldest entry circularly, and underflow sets fault
// without loading the PC.
module ret_stack #(
    parameter int         DEPTH    = 8,
    parameter logic [7:0] TRAP_VEC = 8'hF0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     jump,
    input  logic [7:0]               target,
    input  logic [7:0]               pc,
    input  logic                     clr_fault,
    output logic                     load,
    output logic [7:0]               next,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     fault
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   FULLCNT = (PW+1)'(DEPTH);

    // Entries live in a circular buffer. r_wp points one past the newest entry.
    // When the buffer is full, that slot is also the oldest entry, so an
    // overwriting push naturally lands on the oldest entry.
    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW:0]   r_count;
    logic          r_fault;

    logic [1:0]    w_nreq;
    logic [PW-1:0] w_topIdx;
    logic [7:0]    w_top;
    logic          w_doPush;
    logic          w_doPop;
    logic          w_setFault;

    assign w_nreq   = {1'b0, call} + {1'b0, ret} + {1'b0, jump};
    assign w_topIdx = r_wp - 1'b1;
    assign w_top    = r_mem[w_topIdx];

    assign count = r_count;
    assign full  = (r_count == FULLCNT);
    assign empty = (r_count == '0);
    assign fault = r_fault;

    // Decode the request into PC load outputs plus push/pop/fault actions.
    // Illegal combinations of requests only raise fault; the stack is not touched.
    always_comb begin
        load       = 1'b0;
        next       = 8'h00;
        w_doPush   = 1'b0;
        w_doPop    = 1'b0;
        w_setFault = 1'b0;
        if (en) begin
            if (w_nreq > 2'd1) begin
                w_setFault = 1'b1;
            end else if (jump) begin
                load = 1'b1;
                next = target;
            end else if (call) begin
                if (!full) begin
                    load     = 1'b1;
                    next     = target;
                    w_doPush = 1'b1;
                end else begin
`ifdef RET_STACK_OVF_TRAP_EN
                    load       = 1'b1;
                    next       = TRAP_VEC;
                    w_setFault = 1'b1;
`else
                    load     = 1'b1;
                    next     = target;
                    w_doPush = 1'b1;
`endif
                end
            end else if (ret) begin
                if (!empty) begin
                    load    = 1'b1;
                    next    = w_top;
                    w_doPop = 1'b1;
                end else begin
                    w_setFault = 1'b1;
`ifdef RET_STACK_OVF_TRAP_EN
                    load = 1'b1;
                    next = TRAP_VEC;
`endif
                end
            end
        end
    end

    // Pointer and occupancy. A push while full advances the pointer but holds the count at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp    <= '0;
            r_count <= '0;
        end else if (w_doPush) begin
            r_wp <= r_wp + 1'b1;
            if (!full) begin
                r_count <= r_count + 1'b1;
            end
        end else if (w_doPop) begin
            r_wp    <= r_wp - 1'b1;
            r_count <= r_count - 1'b1;
        end
    end

    // Entry storage holds the return address pc+1, which wraps modulo 256. It needs no reset.
    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wp] <= pc + 8'd1;
        end
    end

    // Sticky fault flag. A new fault event in the same cycle beats clr_fault.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else if (w_setFault) begin
            r_fault <= 1'b1;
        end else if (clr_fault) begin
            r_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ret_stack.sv
// tb_ret_stack: compares ret_stack against a queue-based model of a return stack.
// The same bench covers both builds. It selects its expectations with RET_STACK_OVF_TRAP_EN.
module tb_ret_stack;

    localparam int         DEPTH = 8;
    localparam logic [7:0] TRAP  = 8'hF0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0, call = 1'b0, ret = 1'b0, jump = 1'b0, clr_fault = 1'b0;
    logic [7:0] target = 8'h00, pc = 8'h00;
    logic       load;
    logic [7:0] next;
    logic [3:0] count;
    logic       full, empty, fault;

    int checks   = 0;
    int failures = 0;

    // Reference model state: the back of the queue is the top of the stack.
    logic [7:0] modelQ[$];
    logic       modelFault = 1'b0;
    logic       obsLoad;
    logic [7:0] obsNext;

    ret_stack #(.DEPTH(DEPTH), .TRAP_VEC(TRAP)) dut (
        .clk(clk), .rst(rst), .en(en), .call(call), .ret(ret), .jump(jump),
        .target(target), .pc(pc), .clr_fault(clr_fault),
        .load(load), .next(next), .count(count), .full(full), .empty(empty), .fault(fault)
    );

    // Free-running clock with a 10 ns period.
    always #5 clk = ~clk;

    // Count one comparison, and report it when the observed value differs from the expected value.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Check the registered outputs against the model.
    task automatic checkState(input string tag);
        checkOutput({tag, "_count"}, 32'(count), 32'(modelQ.size()));
        checkOutput({tag, "_full"},  32'(full),  32'(modelQ.size() == DEPTH));
        checkOutput({tag, "_empty"}, 32'(empty), 32'(modelQ.size() == 0));
        checkOutput({tag, "_fault"}, 32'(fault), 32'(modelFault));
    endtask

    // Drive one cycle of inputs at the falling edge. Then check load/next combinationally,
    // let the rising edge happen, update the model and check the registered state.
    task automatic applyStimulus(input logic e, input logic c, input logic r, input logic j,
                                 input logic [7:0] tgt, input logic [7:0] p, input logic clr);
        logic       expLoad;
        logic [7:0] expNext;
        logic       setF;
        int         n;
        @(negedge clk);
        en = e; call = c; ret = r; jump = j; target = tgt; pc = p; clr_fault = clr;
        n = int'(c) + int'(r) + int'(j);
        expLoad = 1'b0; expNext = 8'h00; setF = 1'b0;
        if (e && n > 1) begin
            setF = 1'b1;
        end else if (e && j) begin
            expLoad = 1'b1; expNext = tgt;
        end else if (e && c) begin
            if (modelQ.size() < DEPTH) begin
                expLoad = 1'b1; expNext = tgt;
                modelQ.push_back(p + 8'd1);
            end else begin
`ifdef RET_STACK_OVF_TRAP_EN
                expLoad = 1'b1; expNext = TRAP; setF = 1'b1;
`else
                expLoad = 1'b1; expNext = tgt;
                void'(modelQ.pop_front());
                modelQ.push_back(p + 8'd1);
`endif
            end
        end else if (e && r) begin
            if (modelQ.size() > 0) begin
                expLoad = 1'b1; expNext = modelQ.pop_back();
            end else begin
                setF = 1'b1;
`ifdef RET_STACK_OVF_TRAP_EN
                expLoad = 1'b1; expNext = TRAP;
`endif
            end
        end
        #1;
        obsLoad = load;
        obsNext = next;
        checkOutput("load", 32'(load), 32'(expLoad));
        checkOutput("next", 32'(next), 32'(expNext));
        if (setF) modelFault = 1'b1;
        else if (clr) modelFault = 1'b0;
        @(posedge clk);
        #1;
        checkState("step");
    endtask

    // Synchronous-looking reset pulse that also empties the model.
    task automatic doReset();
        @(negedge clk);
        en = 1'b0; call = 1'b0; ret = 1'b0; jump = 1'b0; clr_fault = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        modelQ.delete();
        modelFault = 1'b0;
    endtask

    initial begin
        // Reset state while rst is still asserted.
        #12;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full",  32'(full),  32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        doReset();

        // A basic CALL followed by RET.
        applyStimulus(1, 1, 0, 0, 8'h40, 8'h10, 0);
        checkOutput("call_next", 32'(obsNext), 32'h40);
        checkOutput("call_count", 32'(count), 32'd1);
        applyStimulus(1, 0, 1, 0, 8'h00, 8'h40, 0);
        checkOutput("ret_load", 32'(obsLoad), 32'd1);
        checkOutput("ret_next", 32'(obsNext), 32'h11);
        checkOutput("ret_count", 32'(count), 32'd0);

        // A return address pushed from pc=FF wraps to 00.
        applyStimulus(1, 1, 0, 0, 8'h33, 8'hFF, 0);
        applyStimulus(1, 0, 1, 0, 8'h00, 8'h33, 0);
        checkOutput("wrap_next", 32'(obsNext), 32'h00);

        // Fill the stack, then do one more CALL past full.
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1, 1, 0, 0, 8'h50, 8'(i), 0);
        applyStimulus(1, 1, 0, 0, 8'h60, 8'h20, 0);
`ifdef RET_STACK_OVF_TRAP_EN
        checkOutput("ovf_next", 32'(obsNext), 32'(TRAP));
        checkOutput("ovf_fault", 32'(fault), 32'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 1, 0, 8'h00, 8'h00, 0);
            checkOutput("ovf_ret", 32'(obsNext), 32'(8'h08 - 8'(i)));
        end
`else
        checkOutput("ovf_next", 32'(obsNext), 32'h60);
        checkOutput("ovf_fault", 32'(fault), 32'd0);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1, 0, 1, 0, 8'h00, 8'h00, 0);
            checkOutput("ovf_ret", 32'(obsNext), (i == 0) ? 32'h21 : 32'(8'h09 - 8'(i)));
        end
        checkOutput("ovf_fault_after", 32'(fault), 32'd0);
`endif

        // Underflow, followed by clearing the fault.
        applyStimulus(1, 0, 1, 0, 8'h00, 8'h00, 0);
`ifdef RET_STACK_OVF_TRAP_EN
        checkOutput("udf_load", 32'(obsLoad), 32'd1);
        checkOutput("udf_next", 32'(obsNext), 32'(TRAP));
`else
        checkOutput("udf_load", 32'(obsLoad), 32'd0);
`endif
        checkOutput("udf_fault", 32'(fault), 32'd1);
        applyStimulus(0, 0, 0, 0, 8'h00, 8'h00, 1);
        checkOutput("clr_fault", 32'(fault), 32'd0);

        // An illegal request combination, and a request while en is low.
        applyStimulus(1, 1, 0, 0, 8'h70, 8'h05, 0);
        applyStimulus(1, 1, 1, 0, 8'h71, 8'h06, 0);
        checkOutput("illegal_load", 32'(obsLoad), 32'd0);
        checkOutput("illegal_count", 32'(count), 32'd1);
        checkOutput("illegal_fault", 32'(fault), 32'd1);
        // A new fault event in the same cycle wins over clr_fault.
        applyStimulus(1, 0, 1, 1, 8'h72, 8'h06, 1);
        checkOutput("fault_prio", 32'(fault), 32'd1);
        applyStimulus(0, 1, 0, 0, 8'h73, 8'h07, 0);
        checkOutput("en0_load", 32'(obsLoad), 32'd0);
        checkOutput("en0_count", 32'(count), 32'd1);

        // An asynchronous reset between edges takes effect immediately.
        applyStimulus(1, 1, 0, 0, 8'h74, 8'h08, 0);
        applyStimulus(1, 1, 0, 0, 8'h75, 8'h09, 0);
        checkOutput("pre_async_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_count", 32'(count), 32'd0);
        checkOutput("async_empty", 32'(empty), 32'd1);
        checkOutput("async_fault", 32'(fault), 32'd0);
        rst = 1'b0;
        modelQ.delete();
        modelFault = 1'b0;
        applyStimulus(1, 0, 1, 0, 8'h00, 8'h00, 0);
        checkOutput("post_rst_udf_fault", 32'(fault), 32'd1);

        // Randomized traffic, biased toward CALL and RET so that full and empty both occur.
        for (int k = 0; k < 400; k++) begin
            int sel;
            logic e, c, r, j, clr;
            sel = int'($urandom_range(0, 19));
            e = ($urandom_range(0, 9) != 0);
            c = 1'b0; r = 1'b0; j = 1'b0;
            if (sel < 8) c = 1'b1;
            else if (sel < 15) r = 1'b1;
            else if (sel < 17) j = 1'b1;
            else if (sel == 17) begin c = 1'b1; r = 1'b1; j = $urandom_range(0, 1) != 0; end
            clr = ($urandom_range(0, 7) == 0);
            applyStimulus(e, c, r, j, 8'($urandom), 8'($urandom), clr);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
